// File: rtl/branch_controller_if.sv
// branch_controller_if -- request/response/flagger bundle for branch_controller.
//   req_*      : branch request handshake plus operands, pc, imm and funct3
//   cmp_a/b    : registered operands sent to the external flagger
//   flag_*     : flagger results for cmp_a versus cmp_b
//   resp_*     : resolution handshake with taken, target and illegal
//   *_count    : resolved-branch and taken-branch statistics
// slave modport is the controller side, master is the requester/flagger side.
interface branch_controller_if #(
  parameter int WORDSIZE = 64,
  parameter int CNTSIZE  = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          funct3;
  logic [WORDSIZE-1:0] rs1_data;
  logic [WORDSIZE-1:0] rs2_data;
  logic [WORDSIZE-1:0] pc;
  logic [WORDSIZE-1:0] imm;
  logic [WORDSIZE-1:0] cmp_a;
  logic [WORDSIZE-1:0] cmp_b;
  logic                flag_equal;
  logic                flag_not_equal;
  logic                flag_greater;
  logic                flag_less;
  logic                flag_u_greater;
  logic                flag_u_less;
  logic                resp_valid;
  logic                resp_ready;
  logic                taken;
  logic [WORDSIZE-1:0] target;
  logic                illegal;
  logic [CNTSIZE-1:0]  branch_count;
  logic [CNTSIZE-1:0]  taken_count;

  modport slave (
    input  req_valid, funct3, rs1_data, rs2_data, pc, imm,
    input  flag_equal, flag_not_equal, flag_greater, flag_less,
    input  flag_u_greater, flag_u_less, resp_ready,
    output req_ready, cmp_a, cmp_b, resp_valid, taken, target, illegal,
    output branch_count, taken_count
  );

  modport master (
    output req_valid, funct3, rs1_data, rs2_data, pc, imm,
    output flag_equal, flag_not_equal, flag_greater, flag_less,
    output flag_u_greater, flag_u_less, resp_ready,
    input  req_ready, cmp_a, cmp_b, resp_valid, taken, target, illegal,
    input  branch_count, taken_count
  );
endinterface

// File: rtl/branch_controller.sv
// branch_controller -- resolves one conditional branch per request.
// Latches the operands onto cmp_a/cmp_b for an external combinational
// flagger, reads its flags one cycle later, and presents taken/target/illegal
// until the consumer accepts. Keeps wrap-around counts of legal and taken
// branches.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : branch_controller_if.slave (request, flagger, response, counters)
//
// state   | meaning
// IDLE    | req_ready=1, waiting for req_valid
// COMPARE | operands on cmp_a/cmp_b, flags sampled at the end of this cycle
// RESP    | resolution held on the bus until resp_ready
module branch_controller #(
  parameter int WORDSIZE = 64,
  parameter int CNTSIZE  = 32
) (
  input logic clk,
  input logic reset,
  branch_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPARE, RESP} state_t;

  state_t              state;
  logic [2:0]          funct3_q;
  logic [WORDSIZE-1:0] pc_q;
  logic [WORDSIZE-1:0] imm_q;
  logic                legal;
  logic                cond;

  // Gated with reset so no request is offered during the reset cycle itself.
  assign bus.req_ready = (state == IDLE) && !reset;

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (funct3_q)
      3'b000:  cond = bus.flag_equal;
      3'b001:  cond = bus.flag_not_equal;
      3'b100:  cond = bus.flag_less;
      3'b101:  cond = bus.flag_greater | bus.flag_equal;
      3'b110:  cond = bus.flag_u_less;
      3'b111:  cond = bus.flag_u_greater | bus.flag_equal;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      funct3_q         <= '0;
      pc_q             <= '0;
      imm_q            <= '0;
      bus.cmp_a        <= '0;
      bus.cmp_b        <= '0;
      bus.resp_valid   <= 1'b0;
      bus.taken        <= 1'b0;
      bus.illegal      <= 1'b0;
      bus.target       <= '0;
      bus.branch_count <= '0;
      bus.taken_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.cmp_a <= bus.rs1_data;
            bus.cmp_b <= bus.rs2_data;
            funct3_q  <= bus.funct3;
            pc_q      <= bus.pc;
            imm_q     <= bus.imm;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          bus.taken      <= legal && cond;
          bus.illegal    <= !legal;
          bus.target     <= (legal && cond) ? pc_q + imm_q : pc_q + WORDSIZE'(4);
          bus.resp_valid <= 1'b1;
          if (legal) begin
            bus.branch_count <= bus.branch_count + 1'b1;
            if (cond) bus.taken_count <= bus.taken_count + 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_controller.sv
// tb_branch_controller -- self-checking bench for branch_controller.
// Two instances share one stimulus stream: a 32-bit-counter instance and a
// 4-bit-counter instance used to observe counter wrap. The flagger is modelled
// as continuous compares on cmp_a/cmp_b; expectations come from a reference
// model working directly on the request operands.
module tb_branch_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  branch_controller_if #(.WORDSIZE(64), .CNTSIZE(32)) bus ();
  branch_controller_if #(.WORDSIZE(64), .CNTSIZE(4))  bus4 ();

  branch_controller #(.WORDSIZE(64), .CNTSIZE(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  branch_controller #(.WORDSIZE(64), .CNTSIZE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  always #5 clk = ~clk;

  // external flagger for each instance
  assign bus.flag_equal      = bus.cmp_a == bus.cmp_b;
  assign bus.flag_not_equal  = bus.cmp_a != bus.cmp_b;
  assign bus.flag_greater    = $signed(bus.cmp_a) > $signed(bus.cmp_b);
  assign bus.flag_less       = $signed(bus.cmp_a) < $signed(bus.cmp_b);
  assign bus.flag_u_greater  = bus.cmp_a > bus.cmp_b;
  assign bus.flag_u_less     = bus.cmp_a < bus.cmp_b;
  assign bus4.flag_equal     = bus4.cmp_a == bus4.cmp_b;
  assign bus4.flag_not_equal = bus4.cmp_a != bus4.cmp_b;
  assign bus4.flag_greater   = $signed(bus4.cmp_a) > $signed(bus4.cmp_b);
  assign bus4.flag_less      = $signed(bus4.cmp_a) < $signed(bus4.cmp_b);
  assign bus4.flag_u_greater = bus4.cmp_a > bus4.cmp_b;
  assign bus4.flag_u_less    = bus4.cmp_a < bus4.cmp_b;

  assign bus4.req_valid  = bus.req_valid;
  assign bus4.funct3     = bus.funct3;
  assign bus4.rs1_data   = bus.rs1_data;
  assign bus4.rs2_data   = bus.rs2_data;
  assign bus4.pc         = bus.pc;
  assign bus4.imm        = bus.imm;
  assign bus4.resp_ready = bus.resp_ready;

  typedef struct packed {
    logic [7:0]  cyc;
    logic        taken;
    logic        illegal;
    logic [63:0] target;
    logic [31:0] bc;
    logic [31:0] tc;
    logic [3:0]  bc4;
    logic [3:0]  tc4;
  } obs_t;

  int          pass_cnt = 0;
  int          total = 0;
  logic [31:0] exp_bc = '0;
  logic [31:0] exp_tc = '0;

  // Reference model: branch semantics from the operands, updates counters.
  function automatic obs_t predict(input logic [2:0] f, input logic [63:0] a, b, p, i);
    obs_t e;
    logic legal, t;
    legal = !(f == 3'b010 || f == 3'b011);
    case (f)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    if (legal) exp_bc = exp_bc + 1;
    if (t) exp_tc = exp_tc + 1;
    e.cyc     = 8'd2;
    e.taken   = t;
    e.illegal = !legal;
    e.target  = t ? p + i : p + 64'd4;
    e.bc      = exp_bc;
    e.tc      = exp_tc;
    e.bc4     = exp_bc[3:0];
    e.tc4     = exp_tc[3:0];
    return e;
  endfunction

  // Presents a request, returns cycles until resp_valid (-1 on timeout).
  task automatic issue(input logic [2:0] f, input logic [63:0] a, b, p, i, output int cyc);
    bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b; bus.pc = p; bus.imm = i;
    bus.req_valid = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic transact(input logic [2:0] f, input logic [63:0] a, b, p, i,
                          input int hold, output obs_t o);
    int cyc;
    issue(f, a, b, p, i, cyc);
    o.cyc     = (cyc < 0) ? 8'hFF : cyc[7:0];
    o.taken   = bus.taken;
    o.illegal = bus.illegal;
    o.target  = bus.target;
    o.bc      = bus.branch_count;
    o.tc      = bus.taken_count;
    o.bc4     = bus4.branch_count;
    o.tc4     = bus4.taken_count;
    repeat (hold) begin @(posedge clk); #1; end
    release_resp();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.taken, bus.illegal} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.req_ready, bus.resp_valid, bus.taken, bus.illegal});
    else pass_cnt++;
    total++;
    if ({bus.cmp_a, bus.cmp_b, bus.target, bus.branch_count, bus.taken_count} !== '0)
      $display("FAIL reset_regs: cmp_a=%h cmp_b=%h target=%h bc=%0d tc=%0d expected all 0",
               bus.cmp_a, bus.cmp_b, bus.target, bus.branch_count, bus.taken_count);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
    else pass_cnt++;
    exp_bc = '0; exp_tc = '0;
  endtask

  task automatic test_directed();
    obs_t o, e;
    e = predict(3'b100, 64'd5, 64'd2, 64'h1000, 64'h20);
    transact(3'b100, 64'd5, 64'd2, 64'h1000, 64'h20, 0, o);
    total++;
    if (o !== e) $display("FAIL blt_model: got %h expected %h", o, e); else pass_cnt++;
    total++;
    if ({o.cyc, o.taken, o.target} !== {8'd2, 1'b0, 64'h1004})
      $display("FAIL blt_const: got cyc=%0d taken=%b target=%h expected 2 0 1004", o.cyc, o.taken, o.target);
    else pass_cnt++;

    e = predict(3'b101, 64'd5, 64'd2, 64'h1000, 64'h20);
    transact(3'b101, 64'd5, 64'd2, 64'h1000, 64'h20, 1, o);
    total++;
    if ({o.taken, o.target} !== {1'b1, 64'h1020} || o !== e)
      $display("FAIL bge: got %h expected %h (taken=1 target=1020)", o, e);
    else pass_cnt++;

    e = predict(3'b100, 64'h2, 64'h1000_0000_0000_0002, 64'h2000, 64'h40);
    transact(3'b100, 64'h2, 64'h1000_0000_0000_0002, 64'h2000, 64'h40, 0, o);
    total++;
    if (o.taken !== 1'b1 || o !== e) $display("FAIL blt_big: got %h expected %h", o, e); else pass_cnt++;

    e = predict(3'b110, 64'h2, 64'h1000_0000_0000_0002, 64'h2000, 64'h40);
    transact(3'b110, 64'h2, 64'h1000_0000_0000_0002, 64'h2000, 64'h40, 0, o);
    total++;
    if (o.taken !== 1'b1 || o !== e) $display("FAIL bltu_big: got %h expected %h", o, e); else pass_cnt++;

    e = predict(3'b000, 64'd5, 64'd5, 64'h3000, 64'hFFFF_FFFF_FFFF_FFF0);
    transact(3'b000, 64'd5, 64'd5, 64'h3000, 64'hFFFF_FFFF_FFFF_FFF0, 0, o);
    total++;
    if ({o.taken, o.target} !== {1'b1, 64'h2FF0} || o !== e)
      $display("FAIL beq: got %h expected %h", o, e);
    else pass_cnt++;

    e = predict(3'b001, 64'd1, 64'd1, 64'h3000, 64'h80);
    transact(3'b001, 64'd1, 64'd1, 64'h3000, 64'h80, 0, o);
    total++;
    if (o.taken !== 1'b0 || o !== e) $display("FAIL bne: got %h expected %h", o, e); else pass_cnt++;
  endtask

  task automatic test_stall();
    obs_t o, e;
    int cyc;
    logic [63:0] a, b;
    a = 64'h0000_0000_0000_0003;
    b = 64'h8000_0000_0000_0009;
    e = predict(3'b111, a, b, 64'h4000, 64'h100);
    issue(3'b111, a, b, 64'h4000, 64'h100, cyc);
    total++;
    if (cyc != 2) $display("FAIL stall_latency: got %0d expected 2", cyc); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 1'b1;
      bus.funct3 = 3'b000; bus.rs1_data = 64'd7; bus.rs2_data = 64'd7;
      @(posedge clk); #1;
      total++;
      if ({bus.req_ready, bus.resp_valid, bus.taken, bus.illegal, bus.target, bus.cmp_a, bus.cmp_b}
          !== {1'b0, 1'b1, e.taken, e.illegal, e.target, a, b})
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b t=%b ill=%b tgt=%h a=%h b=%h expected 0 1 %b %b %h %h %h",
                 k, bus.req_ready, bus.resp_valid, bus.taken, bus.illegal, bus.target, bus.cmp_a, bus.cmp_b,
                 e.taken, e.illegal, e.target, a, b);
      else pass_cnt++;
    end
    bus.req_valid = 1'b0;
    release_resp();
    total++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10)
      $display("FAIL stall_release: got rdy=%b v=%b expected 1 0", bus.req_ready, bus.resp_valid);
    else pass_cnt++;
    total++;
    if ({bus.branch_count, bus.taken_count} !== {exp_bc, exp_tc})
      $display("FAIL stall_ignored_req: got bc=%0d tc=%0d expected %0d %0d",
               bus.branch_count, bus.taken_count, exp_bc, exp_tc);
    else pass_cnt++;
    o = '0;
  endtask

  task automatic test_illegal_and_wrap();
    obs_t o, e;
    logic [63:0] p;
    p = {32'h0, $urandom} & ~64'h3;
    e = predict(3'b010, 64'd9, 64'd9, p, 64'h40);
    transact(3'b010, 64'd9, 64'd9, p, 64'h40, 0, o);
    total++;
    if ({o.illegal, o.taken, o.target} !== {1'b1, 1'b0, p + 64'd4} || o !== e)
      $display("FAIL illegal_010: got %h expected %h", o, e);
    else pass_cnt++;
    e = predict(3'b011, 64'd1, 64'd2, p, 64'h40);
    transact(3'b011, 64'd1, 64'd2, p, 64'h40, 0, o);
    total++;
    if (o !== e) $display("FAIL illegal_011: got %h expected %h", o, e); else pass_cnt++;

    e = predict(3'b001, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40);
    transact(3'b001, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 0, o);
    total++;
    if (o.target !== 64'h0 || o !== e) $display("FAIL pc4_wrap: got %h expected %h", o, e); else pass_cnt++;

    e = predict(3'b000, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    transact(3'b000, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 0, o);
    total++;
    if (o.target !== 64'h10 || o !== e) $display("FAIL imm_wrap: got %h expected %h", o, e); else pass_cnt++;
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [2:0]  f;
    logic [63:0] a, b, p, i;
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 64'h8000_0000_0000_0000;
        2:       b = a + 64'($urandom_range(0, 3)) - 64'd1;
        default: b = {$urandom, $urandom};
      endcase
      p = {$urandom, $urandom};
      i = {{32{1'b1}}, $urandom};
      if (n % 2 == 0) i = {32'h0, $urandom};
      e = predict(f, a, b, p, i);
      transact(f, a, b, p, i, $urandom_range(0, 3), o);
      total++;
      if (o !== e) $display("FAIL random[%0d] f=%b: got %h expected %h", n, f, o, e); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midflight();
    int cyc;
    logic seen;
    bus.funct3 = 3'b000; bus.rs1_data = 64'd4; bus.rs2_data = 64'd4;
    bus.pc = 64'h100; bus.imm = 64'h8;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.resp_valid, bus.req_ready, bus.branch_count, bus.taken_count} !== '0)
      $display("FAIL rst_compare: got v=%b rdy=%b bc=%0d tc=%0d expected 0 0 0 0",
               bus.resp_valid, bus.req_ready, bus.branch_count, bus.taken_count);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL rst_compare_ready: got %b expected 1", bus.req_ready);
    else pass_cnt++;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | bus.resp_valid;
    end
    total++;
    if ({seen, bus.branch_count} !== 33'h0)
      $display("FAIL rst_compare_noresp: got v_seen=%b bc=%0d expected 0 0", seen, bus.branch_count);
    else pass_cnt++;
    exp_bc = '0; exp_tc = '0;

    issue(3'b001, 64'd1, 64'd2, 64'h200, 64'h10, cyc);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.resp_valid, bus.req_ready, bus.taken, bus.target, bus.branch_count} !== {2'b01, 97'h0})
      $display("FAIL rst_resp: got v=%b rdy=%b t=%b tgt=%h bc=%0d expected 0 1 0 0 0",
               bus.resp_valid, bus.req_ready, bus.taken, bus.target, bus.branch_count);
    else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    obs_t o, e;
    for (int n = 1; n <= 16; n++) begin
      e = predict(3'b000, 64'd7, 64'd7, 64'h500, 64'h4);
      transact(3'b000, 64'd7, 64'd7, 64'h500, 64'h4, 0, o);
      if (n == 15) begin
        total++;
        if ({o.bc4, o.tc4} !== 8'hFF) $display("FAIL cnt4_at15: got bc=%0d tc=%0d expected 15 15", o.bc4, o.tc4);
        else pass_cnt++;
      end
    end
    total++;
    if ({bus4.branch_count, bus4.taken_count} !== 8'h00)
      $display("FAIL cnt4_wrap: got bc=%0d tc=%0d expected 0 0", bus4.branch_count, bus4.taken_count);
    else pass_cnt++;
    total++;
    if (o !== e || bus.branch_count !== 32'd16)
      $display("FAIL cnt32_16: got %h bc=%0d expected %h bc=16", o, bus.branch_count, e);
    else pass_cnt++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.pc = '0; bus.imm = '0;
    test_reset();
    test_directed();
    test_stall();
    test_illegal_and_wrap();
    test_random();
    test_reset_midflight();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
